tap_input_controller: RTL and testbench
=======================================

// Module: tap_input_controller
// PURPOSE
//  Produces the `tap` pulse that the box (character) register consumes.
//  Takes the raw active-low pushbutton `key_n`, synchronises it and debounces it.
//  Each debounced press becomes exactly one `tap`, aligned to the game-tick strobe
//  the box register samples on. A minimum spacing between taps (cooldown) is enforced.
//  Sits between the board KEY pin and the box register; also reports a delivered-tap count.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  CLOCK_50 cycles the input must hold a new level to be accepted (>=1)
//  DB_W             20      width of debounce counter; must hold DEBOUNCE_CYCLES-1
//  COOLDOWN_TICKS   2       game ticks after a tap before another tap may fire (0 = none)
//  REPEAT_TICKS     8       auto-repeat period in game ticks (only with TAP_AUTO_REPEAT_EN)
// PORTS
//  CLOCK_50     in   1  system clock; every flop is on its posedge
//  reset        in   1  asynchronous, active-high reset
//  key_n        in   1  raw pushbutton, asynchronous, 0 = pressed
//  game_tick    in   1  one-CLOCK_50-cycle strobe marking a game update
//  tap          out  1  one-cycle pulse, coincident with game_tick, = one flap
//  key_pressed  out  1  debounced key level, 1 = held
//  tap_count    out  8  number of taps delivered, modulo 256
// BEHAVIOUR
//  Reset (async, any time): sync flops=1, stable level=released, debounce cnt=0,
//   FSM=IDLE, queued flag=0, cooldown cnt=0, tap=0, key_pressed=0, tap_count=0.
//   Reset mid-operation discards any pending/queued tap and does not emit one.
//  Sync: 2-flop synchroniser on key_n; the debouncer sees only the second flop.
//  Debounce: if synced != stable, cnt++; when cnt==DEBOUNCE_CYCLES-1 and still
//   differs -> stable<=synced, cnt<=0. If synced==stable, cnt<=0 (glitch rejected).
//   key_pressed = ~stable. Press latency: 2 + DEBOUNCE_CYCLES cycles from key_n fall.
//  press_evt: one-cycle internal event on the cycle stable goes 1->0. Release = no event.
//  FSM states IDLE, PENDING, COOLDOWN:
//   IDLE:     press_evt -> PENDING. press_evt with game_tick in the same cycle still
//             -> PENDING; no tap that tick (tap fires on the next game_tick).
//   PENDING:  game_tick -> tap=1 this cycle. Then cd<=COOLDOWN_TICKS and -> COOLDOWN,
//             or -> IDLE if COOLDOWN_TICKS==0. Further presses while PENDING merge (no tap).
//   COOLDOWN: each game_tick: cd--. When cd reaches 0 -> PENDING if queued, else
//             -> IDLE, and clear queued. press_evt here sets queued (max 1, extras merge).
//  tap = (state==PENDING) & game_tick. Combinational from registered state. Exactly 1
//   cycle wide. Never two taps closer than COOLDOWN_TICKS+1 game ticks.
//  tap_count: +1 on each tap cycle; 8-bit, wraps 255->0 silently.
//  game_tick held high for several cycles is out of contract. Each high cycle counts as a tick.
// CONFIGURATION
//  TAP_AUTO_REPEAT_EN defined: a repeat counter clears on every tap and counts
//   game_ticks while key_pressed=1. When it reaches REPEAT_TICKS in IDLE, it raises a
//   synthetic press_evt (normal FSM rules apply) and clears. Releasing the key clears it.
//  TAP_AUTO_REPEAT_EN undefined: no repeat logic. Holding the key gives one tap only.
// TESTING (bench: DEBOUNCE_CYCLES=4, COOLDOWN_TICKS=2, game_tick every 10 cycles)
//  1 key_n 1->0 held -> key_pressed=1 at cycle 6 after fall. One tap on next game_tick.
//    tap_count=1.
//  2 key_n low for 3 cycles then high -> key_pressed stays 0, no tap, tap_count=0.
//  3 press, release, press again inside cooldown -> 2nd tap exactly 3 ticks after 1st.
//    Three presses in cooldown -> still only one queued tap.
//  4 press_evt coincident with game_tick in IDLE -> no tap that tick, tap next tick.
//  5 reset asserted while PENDING -> tap never fires, all outputs 0 immediately
//    (async, before clock edge). Force tap_count=255, then one tap -> tap_count=0.
//  6 TAP_AUTO_REPEAT_EN, REPEAT_TICKS=8, key held 40 ticks -> taps at ticks 1, 9, 17, 25, 33.
//    Without the macro -> single tap at tick 1.

Source files
------------

// File: rtl/tap_input_controller.sv
// Key synchroniser/debouncer and game-tick aligned tap generator with cooldown and tap counter.
// Optional hold-to-repeat is enabled by defining TAP_AUTO_REPEAT_EN.
module tap_input_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20,
    parameter int unsigned COOLDOWN_TICKS  = 2,
    parameter int unsigned REPEAT_TICKS    = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_n,
    input  logic       game_tick,
    output logic       tap,
    output logic       key_pressed,
    output logic [7:0] tap_count
);

    localparam int unsigned CD_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_TICKS < 1 || ((DEBOUNCE_CYCLES - 1) >> DB_W) != 0) begin : g_param_check
        $error("tap_input_controller: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COOLDOWN} state_t;

    logic [1:0]      sync_q;
    logic            stable_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            key_s;
    logic            db_press_c;
    logic            press_evt;
    state_t          state_q, state_d;
    logic            queued_q, queued_d;
    logic [CD_W-1:0] cd_q, cd_d;

    assign key_s = sync_q[1];

    // Synchroniser and debouncer; stable_q is 1 while released
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            if (key_s != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_q <= key_s;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // True in the cycle whose closing edge turns stable_q from released to pressed
    assign db_press_c  = stable_q & ~key_s & (db_cnt_q == DB_LAST);
    assign key_pressed = ~stable_q;

`ifdef TAP_AUTO_REPEAT_EN
    localparam int unsigned RP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_TICKS - 1);

    logic [RP_W-1:0] rep_q;
    logic            rep_evt;

    // Fires one tick early so the repeated tap lands REPEAT_TICKS after the previous one
    assign rep_evt = key_pressed & (state_q == S_IDLE) & (rep_q >= RP_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
        end else if (!key_pressed || tap || rep_evt) begin
            rep_q <= '0;
        end else if (game_tick && rep_q != RP_LAST) begin
            rep_q <= rep_q + RP_W'(1);
        end
    end

    assign press_evt = db_press_c | rep_evt;
`else
    assign press_evt = db_press_c;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            queued_q <= 1'b0;
            cd_q     <= '0;
        end else begin
            state_q  <= state_d;
            queued_q <= queued_d;
            cd_q     <= cd_d;
        end
    end

    // Tap scheduling: presses in PENDING merge, presses in COOLDOWN queue at most one tap
    always_comb begin
        state_d  = state_q;
        queued_d = queued_q;
        cd_d     = cd_q;
        case (state_q)
            S_IDLE: begin
                if (press_evt) state_d = S_PENDING;
            end
            S_PENDING: begin
                if (game_tick) begin
                    if (COOLDOWN_TICKS == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_COOLDOWN;
                        cd_d    = CD_W'(COOLDOWN_TICKS);
                    end
                end
            end
            S_COOLDOWN: begin
                if (press_evt) queued_d = 1'b1;
                if (game_tick) begin
                    if (cd_q <= CD_W'(1)) begin
                        state_d  = (queued_q || press_evt) ? S_PENDING : S_IDLE;
                        queued_d = 1'b0;
                        cd_d     = '0;
                    end else begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tap = (state_q == S_PENDING) & game_tick;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tap_count <= 8'd0;
        end else if (tap) begin
            tap_count <= tap_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_tap_input_controller.sv
// Bench for tap_input_controller: DEBOUNCE_CYCLES=4, COOLDOWN_TICKS=2, game_tick every 10 cycles.
module tb_tap_input_controller;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       key_n;
    logic       game_tick;
    logic       tap;
    logic       key_pressed;
    logic [7:0] tap_count;

    int checks = 0;
    int failures = 0;

    tap_input_controller #(
        .DEBOUNCE_CYCLES(4),
        .DB_W(3),
        .COOLDOWN_TICKS(2),
        .REPEAT_TICKS(8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .key_n(key_n),
        .game_tick(game_tick),
        .tap(tap),
        .key_pressed(key_pressed),
        .tap_count(tap_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       key;
        logic       tick;
        logic       kp;
        logic       tp;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   tap_ticks[$];
    bit   auto_tick = 1'b0;
    int   phase = 0;
    int   tick_no = 0;
    int   exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic k, input logic t, input logic kp, input logic tp,
                       input logic [7:0] c, input int n);
        vec_t v;
        v = '{key: k, tick: t, kp: kp, tp: tp, cnt: c};
        repeat (n) vecs.push_back(v);
    endtask

    // Finish the current cycle: sample mid-cycle, then start the next cycle just after the edge
    task automatic step();
        @(negedge CLOCK_50);
        if (game_tick) tick_no++;
        if (tap) tap_ticks.push_back(tick_no);
        if (tap && !game_tick) begin
            failures++;
            $display("FAIL tap_without_tick actual=1 expected=0");
        end
        @(posedge CLOCK_50);
        #1;
        if (auto_tick) begin
            phase     = (phase + 1) % 10;
            game_tick = (phase == 9);
        end
    endtask

    // Return at the start of the cycle right after a game_tick cycle
    task automatic align();
        int g;
        g = 0;
        while (game_tick !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        step();
    endtask

    task automatic hold(input logic k, input int n);
        key_n = k;
        repeat (n) step();
    endtask

    task automatic do_tap(input string name);
        int n0;
        int g;
        n0 = tap_ticks.size();
        g  = 0;
        key_n = 1'b0;
        while (tap_ticks.size() == n0 && g < 80) begin
            step();
            g++;
        end
        if (tap_ticks.size() == n0) begin
            failures++;
            $display("FAIL %s_timeout actual=0 expected=1", name);
        end
        hold(1'b1, 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got[$];
        int exp6[$];
        int exp6_total;
        int base;

        reset     = 1'b0;
        key_n     = 1'b1;
        game_tick = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("reset_tap", 32'(tap), 0);
        check("reset_key_pressed", 32'(key_pressed), 0);
        check("reset_tap_count", 32'(tap_count), 0);
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;

        // key, tick, key_pressed, tap, tap_count (count as registered before the cycle's edge)
        add(0, 0, 0, 0, 0, 3);   // 3-cycle glitch is rejected
        add(1, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 4);
        add(0, 0, 0, 0, 0, 5);   // real press; accepted 6 cycles after the fall
        add(0, 1, 0, 0, 0, 1);   // tick coincides with the press event: no tap yet
        add(0, 0, 1, 0, 0, 4);
        add(0, 1, 1, 1, 0, 1);   // tap on the following tick
        add(0, 0, 1, 0, 1, 1);
        add(1, 0, 1, 0, 1, 3);   // release
        add(1, 1, 1, 0, 1, 1);
        add(1, 0, 1, 0, 1, 2);
        add(1, 0, 0, 0, 1, 2);
        add(1, 1, 0, 0, 1, 1);
        add(1, 0, 0, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            key_n     = vecs[i].key;
            game_tick = vecs[i].tick;
            @(negedge CLOCK_50);
            check($sformatf("vec%0d_key_pressed", i), 32'(key_pressed), 32'(vecs[i].kp));
            check($sformatf("vec%0d_tap", i), 32'(tap), 32'(vecs[i].tp));
            check($sformatf("vec%0d_tap_count", i), 32'(tap_count), 32'(vecs[i].cnt));
            @(posedge CLOCK_50);
            #1;
        end
        exp_count = 1;

        auto_tick = 1'b1;
        game_tick = 1'b0;
        key_n     = 1'b1;
        phase     = 0;

        // Second press during cooldown is queued: taps three ticks apart
        align();
        tap_ticks.delete();
        hold(1'b0, 5); hold(1'b1, 7); hold(1'b0, 5); hold(1'b1, 60);
        check("queued_tap_total", 32'(tap_ticks.size()), 2);
        if (tap_ticks.size() == 2) check("queued_tap_spacing", 32'(tap_ticks[1] - tap_ticks[0]), 3);
        exp_count += 2;
        check("queued_tap_count", 32'(tap_count), 32'(exp_count));

        // Three presses after a tap merge into a single queued tap
        align();
        tap_ticks.delete();
        hold(1'b0, 5); hold(1'b1, 7);
        hold(1'b0, 5); hold(1'b1, 5);
        hold(1'b0, 5); hold(1'b1, 5);
        hold(1'b0, 5); hold(1'b1, 60);
        check("merge_tap_total", 32'(tap_ticks.size()), 2);
        if (tap_ticks.size() == 2) check("merge_tap_spacing", 32'(tap_ticks[1] - tap_ticks[0]), 3);
        exp_count += 2;
        check("merge_tap_count", 32'(tap_count), 32'(exp_count));

        // Key held for 40 ticks
`ifdef TAP_AUTO_REPEAT_EN
        exp6 = '{1, 9, 17, 25, 33};
        exp6_total = 6;
`else
        exp6 = '{1};
        exp6_total = 1;
`endif
        align();
        tap_ticks.delete();
        base = tick_no;
        hold(1'b0, 400);
        hold(1'b1, 60);
        foreach (tap_ticks[i]) if (tap_ticks[i] - base <= 40) got.push_back(tap_ticks[i] - base);
        check("hold_tap_total", 32'(got.size()), 32'(exp6.size()));
        for (int i = 0; i < exp6.size() && i < got.size(); i++)
            check($sformatf("hold_tap%0d_tick", i), 32'(got[i]), 32'(exp6[i]));
        exp_count = (exp_count + exp6_total) % 256;
        check("hold_tap_count", 32'(tap_count), 32'(exp_count));

        // Asynchronous reset while a tap is pending
        align();
        hold(1'b0, 7);
        check("pending_key_pressed", 32'(key_pressed), 1);
        auto_tick = 1'b0;
        game_tick = 1'b1;
        #1;
        check("pending_tap_visible", 32'(tap), 1);
        reset = 1'b1;
        #1;
        check("async_reset_tap", 32'(tap), 0);
        check("async_reset_key_pressed", 32'(key_pressed), 0);
        check("async_reset_tap_count", 32'(tap_count), 0);
        key_n     = 1'b1;
        game_tick = 1'b0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        auto_tick = 1'b1;
        phase     = 0;
        tap_ticks.delete();
        hold(1'b1, 40);
        check("post_reset_no_tap", 32'(tap_ticks.size()), 0);
        check("post_reset_tap_count", 32'(tap_count), 0);

        // Counter wrap: 255 taps, then one more returns to 0
        for (int i = 0; i < 255; i++) do_tap("wrap_fill");
        check("wrap_count_255", 32'(tap_count), 255);
        do_tap("wrap_last");
        check("wrap_count_0", 32'(tap_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
